// File: rtl/img_tx_pkg.sv
// Shared types and frame constants for image_uart_tx.
// IMG_TX_CHECKSUM_EN adds the CSUM state for the trailing XOR checksum byte.
package img_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    SEND,
`ifdef IMG_TX_CHECKSUM_EN
    CSUM,
`endif
    FINISH
  } state_t;

  localparam int BITS_PER_FRAME = 10;
  localparam int DATA_BITS      = 8;
  localparam int BYTES_PER_WORD = 4;

  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with a load/ready handshake that allows back-to-back frames.
// near_end flags the cycle four cycles before the frame ends so the caller can prefetch.
module uart_tx_byte
  import img_tx_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] data,
  output logic                 ready,
  output logic                 near_end,
  output logic                 tx
);

  localparam int CNT_W     = $clog2(CLK_DIV);
  localparam int NEAR_IDX  = BITS_PER_FRAME * CLK_DIV - 4;
  localparam int NEAR_BIT  = NEAR_IDX / CLK_DIV;
  localparam int NEAR_BAUD = NEAR_IDX % CLK_DIV;

  logic [BITS_PER_FRAME-1:0] shreg;
  logic [CNT_W-1:0]          baud_cnt;
  logic [3:0]                bit_cnt;
  logic                      active;
  logic                      bit_end;
  logic                      frame_end;

  assign bit_end   = (baud_cnt == CNT_W'(CLK_DIV - 1));
  assign frame_end = active && bit_end && (bit_cnt == 4'(BITS_PER_FRAME - 1));
  assign ready     = !active || frame_end;
  assign near_end  = active && (bit_cnt == 4'(NEAR_BIT)) && (baud_cnt == CNT_W'(NEAR_BAUD));
  assign tx        = shreg[0];

  // Shifting ones in behind the stop bit leaves the line idle high after each frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      active   <= 1'b0;
    end else if (load && ready) begin
      shreg    <= {1'b1, data, 1'b0};
      baud_cnt <= '0;
      bit_cnt  <= '0;
      active   <= 1'b1;
    end else if (active) begin
      if (bit_end) begin
        baud_cnt <= '0;
        shreg    <= {1'b1, shreg[BITS_PER_FRAME-1:1]};
        if (bit_cnt == 4'(BITS_PER_FRAME - 1)) begin
          active <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/image_uart_tx.sv
// Streams NUM_WORDS words from data memory as 8N1 bytes, LSB byte first.
// Define IMG_TX_CHECKSUM_EN to append an XOR checksum byte after the data.
module image_uart_tx
  import img_tx_pkg::*;
#(
  parameter int CLK_DIV   = 434,
  parameter int ADDR_W    = 10,
  parameter int NUM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   words_left;
  logic [31:0]       word_reg;
  logic [2:0]        byte_idx;
  logic              done_q;
  logic              uart_load;
  logic              uart_ready;
  logic              uart_near_end;
  logic [7:0]        uart_data;
`ifdef IMG_TX_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  uart_tx_byte #(.CLK_DIV(CLK_DIV)) u_uart (
    .clk      (clk),
    .rst      (rst),
    .load     (uart_load),
    .data     (uart_data),
    .ready    (uart_ready),
    .near_end (uart_near_end),
    .tx       (tx)
  );

  assign mem_rd_en = (state == FETCH);
  assign mem_addr  = addr;
  assign busy      = (state != IDLE);
  assign done      = done_q;

  // The next word is fetched off near_end so it is captured just in time for the
  // load that lands on the final stop-bit cycle of byte 3.
  always_comb begin
    state_next = state;
    uart_load  = 1'b0;
    uart_data  = word_byte(word_reg, byte_idx[1:0]);
    case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   state_next = CAPTURE;
      CAPTURE: state_next = SEND;
      SEND: begin
        if (byte_idx != 3'(BYTES_PER_WORD)) begin
          uart_load = 1'b1;
        end else if (words_left != '0) begin
          if (uart_near_end) state_next = FETCH;
        end else begin
`ifdef IMG_TX_CHECKSUM_EN
          state_next = CSUM;
`else
          state_next = FINISH;
`endif
        end
      end
`ifdef IMG_TX_CHECKSUM_EN
      CSUM: begin
        uart_load = 1'b1;
        uart_data = csum;
        if (uart_ready) state_next = FINISH;
      end
`endif
      FINISH:  if (uart_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      words_left <= '0;
      word_reg   <= '0;
      byte_idx   <= '0;
      done_q     <= 1'b0;
`ifdef IMG_TX_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      state  <= state_next;
      done_q <= (state == FINISH) && uart_ready;
      if (state == IDLE && start) begin
        addr       <= base_addr;
        words_left <= (ADDR_W+1)'(NUM_WORDS);
`ifdef IMG_TX_CHECKSUM_EN
        csum       <= '0;
`endif
      end
      if (state == FETCH) begin
        addr       <= addr + ADDR_W'(1);
        words_left <= words_left - (ADDR_W+1)'(1);
      end
      if (state == CAPTURE) begin
        word_reg <= mem_rdata;
        byte_idx <= '0;
      end
      if (state == SEND && uart_load && uart_ready) begin
        byte_idx <= byte_idx + 3'd1;
`ifdef IMG_TX_CHECKSUM_EN
        csum     <= csum ^ uart_data;
`endif
      end
    end
  end

endmodule
